// File: rtl/im_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : im_line_responder
// Purpose  : Memory-side word responder for L1I refills over a fixed-latency
//            single-port instruction SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module im_line_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_AW  = 14,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IM_enable,
    input  logic [ADDR_W-1:0] IM_address,
    output logic [DATA_W-1:0] IM_data,
    output logic              ready,
    output logic              bus_err,
    output logic              mem_CS,
    output logic              mem_OE,
    output logic [MEM_AW-1:0] mem_A,
    input  logic [DATA_W-1:0] mem_DO,
    output logic [31:0]       beat_cnt
);

    localparam logic [3:0] c_LAST_WAIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-3:0] r_served_addr;
    logic              r_oor;
    logic [3:0]        r_wait_cnt;
    logic              w_oor;
    logic              w_match;
    logic              w_start;
    logic              w_done;
    logic              w_unused_lsb;

    // Byte-lane bits never select a different word.
    assign w_unused_lsb = ^IM_address[1:0];

    generate
        if (ADDR_W > MEM_AW + 2) begin : g_oor
            assign w_oor = |IM_address[ADDR_W-1:MEM_AW+2];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_match = (IM_address[ADDR_W-1:2] == r_served_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (IM_enable) begin
                    w_next  = S_ACCESS;
                    w_start = 1'b1;
                end
            end
            S_ACCESS: begin
                // A dropped request wins over completion, so no partial beat is counted.
                if (!IM_enable) begin
                    w_next = S_IDLE;
                end else if (r_wait_cnt == c_LAST_WAIT) begin
                    w_next = S_RESP;
                    w_done = 1'b1;
                end
            end
            S_RESP: begin
                if (!IM_enable) begin
                    w_next = S_IDLE;
                end else if (!w_match) begin
                    w_next  = S_ACCESS;
                    w_start = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign ready  = (r_state == S_RESP) && IM_enable && w_match;
    assign mem_CS = (r_state == S_ACCESS) && !r_oor;
    assign mem_OE = mem_CS;
    assign mem_A  = r_served_addr[MEM_AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_served_addr <= '0;
            r_oor         <= 1'b0;
            r_wait_cnt    <= 4'd0;
            IM_data       <= '0;
            bus_err       <= 1'b0;
            beat_cnt      <= 32'd0;
        end else begin
            if (w_start) begin
                r_served_addr <= IM_address[ADDR_W-1:2];
                r_oor         <= w_oor;
                r_wait_cnt    <= 4'd0;
                bus_err       <= 1'b0;
            end else if (r_state == S_ACCESS) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            if (w_done) begin
                IM_data  <= r_oor ? '0 : mem_DO;
                bus_err  <= r_oor;
                beat_cnt <= beat_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_line_responder
// Purpose  : Randomised bench with a reference model for LATENCY 2 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_line_responder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] addr;

    logic [31:0] d0_data, d1_data, d0_beats, d1_beats, do0, do1;
    logic        d0_ready, d1_ready, d0_err, d1_err, d0_cs, d1_cs, d0_oe, d1_oe;
    logic [13:0] d0_a, d1_a;

    logic [31:0] mem [0:16383];

    int vectors;
    int miscompares;

    // Reference state per DUT: index 0 is LATENCY=2, index 1 is LATENCY=4.
    int          acc_left [2];
    bit          m_hold   [2];
    logic [29:0] m_saddr  [2];
    bit          m_oor    [2];
    logic [31:0] m_data   [2];
    bit          m_err    [2];
    logic [31:0] m_beats  [2];

    bit          seen [2];
    logic [31:0] cap_data0, cap_beats0;
    logic        cap_cs0, cap_err0;

    im_line_responder #(.DATA_W(32), .ADDR_W(32), .MEM_AW(14), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .IM_enable(en), .IM_address(addr),
        .IM_data(d0_data), .ready(d0_ready), .bus_err(d0_err),
        .mem_CS(d0_cs), .mem_OE(d0_oe), .mem_A(d0_a), .mem_DO(do0),
        .beat_cnt(d0_beats)
    );

    im_line_responder #(.DATA_W(32), .ADDR_W(32), .MEM_AW(14), .LATENCY(4)) dut1 (
        .clk(clk), .rst(rst), .IM_enable(en), .IM_address(addr),
        .IM_data(d1_data), .ready(d1_ready), .bus_err(d1_err),
        .mem_CS(d1_cs), .mem_OE(d1_oe), .mem_A(d1_a), .mem_DO(do1),
        .beat_cnt(d1_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: data appears the cycle after a selected edge, garbage otherwise.
    always @(posedge clk) do0 <= (d0_cs && d0_oe) ? mem[d0_a] : $urandom;
    always @(posedge clk) do1 <= (d1_cs && d1_oe) ? mem[d1_a] : $urandom;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        acc_left[k] = 0;
        m_hold[k]   = 1'b0;
        m_saddr[k]  = '0;
        m_oor[k]    = 1'b0;
        m_data[k]   = '0;
        m_err[k]    = 1'b0;
        m_beats[k]  = '0;
    endtask

    task automatic model_start(input int k, input logic [29:0] wa);
        m_saddr[k]  = wa;
        m_oor[k]    = (wa[29:14] != 16'd0);
        acc_left[k] = lat_of(k);
        m_hold[k]   = 1'b0;
        m_err[k]    = 1'b0;
    endtask

    task automatic model_step(input int k);
        logic [29:0] wa;
        wa = addr[31:2];
        if (acc_left[k] > 0) begin
            if (!en) begin
                acc_left[k] = 0;
            end else if (acc_left[k] == 1) begin
                acc_left[k] = 0;
                m_data[k]   = m_oor[k] ? 32'd0 : mem[m_saddr[k][13:0]];
                m_err[k]    = m_oor[k];
                m_beats[k]  = m_beats[k] + 32'd1;
                m_hold[k]   = 1'b1;
            end else begin
                acc_left[k] = acc_left[k] - 1;
            end
        end else if (m_hold[k]) begin
            if (!en) m_hold[k] = 1'b0;
            else if (wa != m_saddr[k]) model_start(k, wa);
        end else if (en) begin
            model_start(k, wa);
        end
    endtask

    task automatic compare_dut(input int k, input logic rdy, input logic [31:0] data,
                               input logic err, input logic cs, input logic oe,
                               input logic [13:0] a, input logic [31:0] bc);
        logic er, ecs;
        er  = m_hold[k] && en && (addr[31:2] == m_saddr[k]);
        ecs = (acc_left[k] > 0) && !m_oor[k];
        chk($sformatf("ready_L%0d", lat_of(k)), 32'(rdy), 32'(er));
        chk($sformatf("IM_data_L%0d", lat_of(k)), data, m_data[k]);
        chk($sformatf("beat_cnt_L%0d", lat_of(k)), bc, m_beats[k]);
        chk($sformatf("mem_CS_L%0d", lat_of(k)), 32'(cs), 32'(ecs));
        chk($sformatf("mem_OE_L%0d", lat_of(k)), 32'(oe), 32'(ecs));
        chk($sformatf("mem_A_L%0d", lat_of(k)), 32'(a), 32'(m_saddr[k][13:0]));
        if (er) chk($sformatf("bus_err_L%0d", lat_of(k)), 32'(err), 32'(m_err[k]));
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_dut(0, d0_ready, d0_data, d0_err, d0_cs, d0_oe, d0_a, d0_beats);
        compare_dut(1, d1_ready, d1_data, d1_err, d1_cs, d1_oe, d1_a, d1_beats);
        seen[0]    = d0_ready;
        seen[1]    = d1_ready;
        cap_data0  = d0_data;
        cap_beats0 = d0_beats;
        cap_cs0    = d0_cs;
        cap_err0   = d0_err;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) model_reset(k);
            else model_step(k);
        end
        #1;
    endtask

    // Counts cycles from the current input set until ready is seen; lim+1 on timeout.
    task automatic wait_ready(input int k, input int lim, output int n);
        int i;
        for (i = 0; i <= lim; i++) begin
            cyc();
            if (seen[k]) break;
        end
        n = i;
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16'h40 + i] = 32'hA0 + 32'(i);
        model_reset(0);
        model_reset(1);
        rst  = 1'b0;
        en   = 1'b0;
        addr = 32'd0;
        do0  = 32'd0;
        do1  = 32'd0;

        repeat (2) cyc();
        chk("reset_IM_data", d0_data, 32'd0);
        chk("reset_ready", 32'(d0_ready), 32'd0);
        chk("reset_beat_cnt", d0_beats, 32'd0);
        chk("reset_mem_A", 32'(d0_a), 32'd0);
        rst = 1'b1;

        // Line refill with a stall on the second word.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h100 + 32'(4 * i);
            wait_ready(0, 10, n);
            chk($sformatf("refill_latency_%0d", i), 32'(n), 32'd3);
            chk($sformatf("refill_data_%0d", i), cap_data0, 32'hA0 + 32'(i));
            if (i == 1) begin
                for (int s = 0; s < 5; s++) begin
                    cyc();
                    chk("stall_ready", 32'(seen[0]), 32'd1);
                    chk("stall_data", cap_data0, 32'hA1);
                    chk("stall_cs", 32'(cap_cs0), 32'd0);
                    chk("stall_beats", cap_beats0, 32'd2);
                end
            end
        end
        chk("refill_beats", cap_beats0, 32'd4);

        // Abort on the second ACCESS cycle.
        addr = 32'h200;
        for (int s = 0; s < 6; s++) begin
            if (s == 2) en = 1'b0;
            cyc();
            chk("abort_ready", 32'(seen[0]), 32'd0);
            chk("abort_data", cap_data0, 32'hA3);
            chk("abort_beats", cap_beats0, 32'd4);
        end

        // Out-of-range then a legal word.
        en   = 1'b1;
        addr = 32'h0001_0000;
        wait_ready(0, 10, n);
        chk("oor_latency", 32'(n), 32'd3);
        chk("oor_bus_err", 32'(cap_err0), 32'd1);
        chk("oor_data", cap_data0, 32'd0);
        addr = 32'h10;
        wait_ready(0, 10, n);
        chk("legal_bus_err", 32'(cap_err0), 32'd0);
        chk("legal_data", cap_data0, mem[4]);

        // Asynchronous reset while accessing.
        addr = 32'h300;
        cyc();
        rst = 1'b0;
        #2;
        chk("arst_data", d0_data, 32'd0);
        chk("arst_ready", 32'(d0_ready), 32'd0);
        chk("arst_cs", 32'(d0_cs), 32'd0);
        chk("arst_beats", d0_beats, 32'd0);
        chk("arst_mem_A", 32'(d0_a), 32'd0);
        model_reset(0);
        model_reset(1);
        repeat (2) cyc();
        rst  = 1'b1;
        addr = 32'h20;
        wait_ready(0, 10, n);
        chk("post_reset_latency", 32'(n), 32'd3);
        chk("post_reset_data", cap_data0, mem[8]);

        // Single request timed on the LATENCY=4 instance.
        en = 1'b0;
        repeat (2) cyc();
        en   = 1'b1;
        addr = 32'h44;
        wait_ready(1, 12, n);
        chk("lat4_latency", 32'(n), 32'd5);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst = 1'b0;
                model_reset(0);
                model_reset(1);
            end else begin
                rst = 1'b1;
            end
            en = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 30) begin
                case ($urandom_range(0, 5))
                    0, 1, 2, 3: addr = 32'h100 + 32'(4 * $urandom_range(0, 3));
                    4:          addr = 32'($urandom_range(0, 16383)) << 2;
                    default:    addr = $urandom | 32'h0001_0000;
                endcase
                addr[1:0] = 2'($urandom_range(0, 3));
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
